// File: rtl/dds_pkg.sv
// Shared widths, state encoding and configuration record for the DDS phase generator.
package dds_pkg;

  localparam int ACC_W   = 24;
  localparam int PHASE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2
  } state_t;

  // One complete configuration; the shadow and the active copy share this shape.
  typedef struct packed {
    logic [ACC_W-1:0]   ftw;
    logic [PHASE_W-1:0] offset;
    logic [ACC_W-1:0]   step;
    logic [ACC_W-1:0]   end_ftw;
  } cfg_t;

  // A sweep only makes sense when there is a non-zero step and room to climb.
  function automatic logic sweep_wanted(input cfg_t c);
    return (c.step != '0) && (c.ftw < c.end_ftw);
  endfunction

endpackage

// File: rtl/dds_phase_gen.sv
// Phase accumulator with shadowed configuration applied at accumulator wrap,
// programmable phase offset and an optional linear tuning-word sweep.
module dds_phase_gen
  import dds_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               sync,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [ACC_W-1:0]   cfg_ftw,
  input  logic [PHASE_W-1:0] cfg_offset,
  input  logic [ACC_W-1:0]   cfg_step,
  input  logic [ACC_W-1:0]   cfg_end,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic               wrap,
  output logic               sweep_done
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;     // carry-out that travels with acc_q
  cfg_t               act_q, act_d;
  cfg_t               shadow_q, shadow_d;
  logic               pending_q, pending_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               phase_valid_q;
  logic               wrap_q;
  logic               sweep_done_q, sweep_done_d;

  logic               running;
  logic               accept;
  logic               apply;
  logic [ACC_W:0]     acc_sum;
  logic [ACC_W:0]     sweep_sum;

  // Next-state logic: accumulation, handshake, shadow apply, sweep and FSM.
  always_comb begin
    running   = (state_q != IDLE);
    accept    = cfg_valid && !pending_q;
    // Idle applies right away; running waits for the cycle after a wrap so
    // the frequency change lands on a phase boundary. sync blocks the apply.
    apply     = pending_q && !sync && (running ? carry_q : 1'b1);
    acc_sum   = {1'b0, acc_q} + {1'b0, act_q.ftw};
    sweep_sum = {1'b0, act_q.ftw} + {1'b0, act_q.step};

    acc_d        = acc_q;
    carry_d      = 1'b0;
    act_d        = act_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    sweep_done_d = 1'b0;
    state_d      = state_q;

    // sync wins over accumulation and swallows any carry of this cycle
    if (sync) begin
      acc_d = '0;
    end else if (running) begin
      acc_d   = acc_sum[ACC_W-1:0];
      carry_d = acc_sum[ACC_W];
    end

    if (accept) begin
      shadow_d  = {cfg_ftw, cfg_offset, cfg_step, cfg_end};
      pending_d = 1'b1;
    end

    // A fresh configuration overrides the sweep update on the same wrap.
    // The addition above always uses the old tuning word.
    if (apply) begin
      act_d     = shadow_q;
      pending_d = 1'b0;
    end else if (state_q == SWEEP && carry_q) begin
      if (sweep_sum >= {1'b0, act_q.end_ftw}) begin
        act_d.ftw    = act_q.end_ftw;
        sweep_done_d = 1'b1;
      end else begin
        act_d.ftw = sweep_sum[ACC_W-1:0];
      end
    end

    if (!enable) begin
      state_d = IDLE;
    end else if (apply || state_q == IDLE) begin
      state_d = sweep_wanted(act_d) ? SWEEP : RUN;
    end else if (sweep_done_d) begin
      state_d = RUN;
    end

    phase_d = acc_q[ACC_W-1 -: PHASE_W] + act_q.offset;
  end

  // State and output registers; reset discards any pending configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      act_q         <= '0;
      shadow_q      <= '0;
      pending_q     <= 1'b0;
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      wrap_q        <= 1'b0;
      sweep_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      carry_q       <= carry_d;
      act_q         <= act_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      phase_q       <= phase_d;
      phase_valid_q <= running;
      wrap_q        <= carry_q;
      sweep_done_q  <= sweep_done_d;
    end
  end

  assign cfg_ready   = !pending_q;
  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign wrap        = wrap_q;
  assign sweep_done  = sweep_done_q;

endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed self-checking bench for dds_phase_gen.
module tb_dds_phase_gen;
  import dds_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               enable;
  logic               sync;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [ACC_W-1:0]   cfg_ftw;
  logic [PHASE_W-1:0] cfg_offset;
  logic [ACC_W-1:0]   cfg_step;
  logic [ACC_W-1:0]   cfg_end;
  logic [PHASE_W-1:0] phase;
  logic               phase_valid;
  logic               wrap;
  logic               sweep_done;

  int checks   = 0;
  int failures = 0;

  dds_phase_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sync       (sync),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ftw    (cfg_ftw),
    .cfg_offset (cfg_offset),
    .cfg_step   (cfg_step),
    .cfg_end    (cfg_end),
    .phase      (phase),
    .phase_valid(phase_valid),
    .wrap       (wrap),
    .sweep_done (sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [ACC_W-1:0] ftw, input logic [PHASE_W-1:0] off,
                          input logic [ACC_W-1:0] step, input logic [ACC_W-1:0] endv);
    int n;
    n = 0;
    while (cfg_ready !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
    cfg_valid  = 1'b1;
    cfg_ftw    = ftw;
    cfg_offset = off;
    cfg_step   = step;
    cfg_end    = endv;
    tick();
    cfg_valid  = 1'b0;
    $display("cfg ftw=0x%06h offset=0x%02h step=0x%06h end=0x%06h accepted at %0t",
             ftw, off, step, endv, $time);
  endtask

  // Stop, clear the accumulator, load a config in IDLE and start again.
  // Returns at the first sample where phase reflects acc=0.
  task automatic restart(input logic [ACC_W-1:0] ftw, input logic [PHASE_W-1:0] off,
                         input logic [ACC_W-1:0] step, input logic [ACC_W-1:0] endv);
    enable = 1'b0;
    sync   = 1'b1;
    tick();
    sync   = 1'b0;
    tick();
    send_cfg(ftw, off, step, endv);
    check("restart_ready_low", {31'd0, cfg_ready}, 32'd0);
    enable = 1'b1;
    tick();
    check("restart_ready_back", {31'd0, cfg_ready}, 32'd1);
    tick();
  endtask

  task automatic wait_phase(input logic [PHASE_W-1:0] target);
    int n;
    n = 0;
    while (phase !== target && n < 600) begin
      tick();
      n++;
    end
    check("wait_phase", {24'd0, phase}, {24'd0, target});
  endtask

  logic [7:0] exp_ph;
  logic [7:0] prev_ph;
  logic [7:0] d_ph;
  logic [7:0] last_d;
  logic [7:0] deltas [8];
  int         ndelta;
  int         wraps;
  int         dones;
  int         wraps_at_done;

  initial begin
    rst_n      = 1'b0;
    enable     = 1'b0;
    sync       = 1'b0;
    cfg_valid  = 1'b0;
    cfg_ftw    = '0;
    cfg_offset = '0;
    cfg_step   = '0;
    cfg_end    = '0;

    // reset values
    #2;
    check("rst_phase", {24'd0, phase}, 32'd0);
    check("rst_valid", {31'd0, phase_valid}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    check("rst_done", {31'd0, sweep_done}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd1);
    #20;
    rst_n = 1'b1;
    tick();

    // unit step: phase counts, wrap aligned with phase 0x00 after 256 cycles
    restart(24'h010000, 8'h00, 24'h0, 24'h0);
    for (int k = 0; k <= 256; k++) begin
      if (k > 0) tick();
      check("count_phase", {24'd0, phase}, k % 256);
      check("count_wrap", {31'd0, wrap}, (k == 256) ? 32'd1 : 32'd0);
    end
    check("count_valid", {31'd0, phase_valid}, 32'd1);

    // half-scale step with offset: 0x40/0xC0, wrap every 2 cycles
    restart(24'h800000, 8'h40, 24'h0, 24'h0);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      exp_ph = (k % 2 == 0) ? 8'h40 : 8'hC0;
      check("half_phase", {24'd0, phase}, {24'd0, exp_ph});
      check("half_wrap", {31'd0, wrap}, (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // config offered while running waits for the wrap
    restart(24'h010000, 8'h00, 24'h0, 24'h0);
    for (int k = 1; k <= 16; k++) tick();
    check("pre_offer_phase", {24'd0, phase}, 32'h10);
    send_cfg(24'h020000, 8'h00, 24'h0, 24'h0);
    for (int k = 17; k <= 259; k++) begin
      if (k > 17) tick();
      if (k <= 256) exp_ph = 8'(k % 256);
      else if (k == 257) exp_ph = 8'h01;
      else if (k == 258) exp_ph = 8'h03;
      else exp_ph = 8'h05;
      check("live_phase", {24'd0, phase}, {24'd0, exp_ph});
      check("live_ready", {31'd0, cfg_ready}, (k >= 256) ? 32'd1 : 32'd0);
      check("live_wrap", {31'd0, wrap}, (k == 256) ? 32'd1 : 32'd0);
    end

    // sweep 1 -> 2 -> 3 -> 4 (x 0x010000), one sweep_done, then stays at 4
    restart(24'h010000, 8'h00, 24'h010000, 24'h040000);
    prev_ph       = phase;
    last_d        = 8'd0;
    ndelta        = 0;
    wraps         = 0;
    dones         = 0;
    wraps_at_done = 0;
    for (int i = 0; i < 8; i++) deltas[i] = 8'd0;
    for (int i = 0; i < 900; i++) begin
      tick();
      d_ph    = phase - prev_ph;
      prev_ph = phase;
      if (wrap) wraps++;
      if (sweep_done) begin
        dones++;
        wraps_at_done = wraps;
      end
      if (d_ph != last_d) begin
        if (ndelta < 8) deltas[ndelta] = d_ph;
        ndelta++;
        last_d = d_ph;
      end
    end
    check("sweep_nsteps", ndelta, 32'd4);
    check("sweep_step0", {24'd0, deltas[0]}, 32'd1);
    check("sweep_step1", {24'd0, deltas[1]}, 32'd2);
    check("sweep_step2", {24'd0, deltas[2]}, 32'd3);
    check("sweep_step3", {24'd0, deltas[3]}, 32'd4);
    check("sweep_done_count", dones, 32'd1);
    check("sweep_done_wraps", wraps_at_done, 32'd3);

    // sync at phase 0x80: phase reads 0x00 two cycles later, no wrap
    restart(24'h010000, 8'h00, 24'h0, 24'h0);
    wait_phase(8'h80);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_ph1", {24'd0, phase}, 32'h81);
    check("sync_wr1", {31'd0, wrap}, 32'd0);
    tick();
    check("sync_ph2", {24'd0, phase}, 32'h00);
    check("sync_wr2", {31'd0, wrap}, 32'd0);
    tick();
    check("sync_ph3", {24'd0, phase}, 32'h01);

    // sync on the cycle that would carry: the wrap is swallowed
    wait_phase(8'hFE);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_carry_ph1", {24'd0, phase}, 32'hFF);
    tick();
    check("sync_carry_ph2", {24'd0, phase}, 32'h00);
    check("sync_carry_wr2", {31'd0, wrap}, 32'd0);
    tick();
    check("sync_carry_ph3", {24'd0, phase}, 32'h01);
    check("sync_carry_wr3", {31'd0, wrap}, 32'd0);

    // enable off/on: phase holds, phase_valid dips
    enable = 1'b0;
    tick();
    check("en_a_phase", {24'd0, phase}, 32'h02);
    check("en_a_valid", {31'd0, phase_valid}, 32'd1);
    tick();
    check("en_b_phase", {24'd0, phase}, 32'h03);
    check("en_b_valid", {31'd0, phase_valid}, 32'd0);
    tick();
    check("en_c_phase", {24'd0, phase}, 32'h03);
    check("en_c_valid", {31'd0, phase_valid}, 32'd0);
    enable = 1'b1;
    tick();
    check("en_d_phase", {24'd0, phase}, 32'h03);
    check("en_d_valid", {31'd0, phase_valid}, 32'd0);
    tick();
    check("en_e_phase", {24'd0, phase}, 32'h03);
    check("en_e_valid", {31'd0, phase_valid}, 32'd1);
    tick();
    check("en_f_phase", {24'd0, phase}, 32'h04);

    // reset mid-sweep with a pending config
    restart(24'h010000, 8'h00, 24'h010000, 24'h040000);
    for (int i = 0; i < 50; i++) tick();
    send_cfg(24'h200000, 8'h00, 24'h0, 24'h0);
    check("pend_ready", {31'd0, cfg_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_phase", {24'd0, phase}, 32'd0);
    check("mid_rst_valid", {31'd0, phase_valid}, 32'd0);
    check("mid_rst_wrap", {31'd0, wrap}, 32'd0);
    check("mid_rst_done", {31'd0, sweep_done}, 32'd0);
    check("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_phase", {24'd0, phase}, 32'd0);
    end
    check("post_rst_valid", {31'd0, phase_valid}, 32'd1);
    check("post_rst_ready", {31'd0, cfg_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
